// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic RX_IDLE_LVL = 1'b1;
    localparam int   MIN_K       = 4;

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX line; flops reset to the idle level.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift chain; the last stage is the only copy of rx the engine may observe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RX_IDLE_LVL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-bit validation, mid-bit sampling of data/parity/stop,
// and a held byte with ready and error status until the core acknowledges it.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int K_W         = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    input  logic [K_W-1:0] k,
    input  logic           eight,
    input  logic           pen,
    input  logic           ohel,
    input  logic           clr_rdy,
    output logic [7:0]     rx_data,
    output logic           rxrdy,
    output logic           perr,
    output logic           ferr,
    output logic           ovf
);

    rx_state_t      state_r, state_nxt_s;
    logic [K_W-1:0] tick_r, tick_nxt_s, k_eff_s, half_last_s, bit_last_s;
    logic [3:0]     bit_idx_r, bit_idx_nxt_s, nbits_s;
    logic [8:0]     shreg_r, shreg_nxt_s, frame_s;
    logic [7:0]     data_s;
    logic           armed_r, armed_nxt_s, load_s, rx_s, par_bit_s, perr_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    assign k_eff_s     = (k < K_W'(MIN_K)) ? K_W'(MIN_K) : k;
    assign half_last_s = (k_eff_s >> 1) - K_W'(1);
    assign bit_last_s  = k_eff_s - K_W'(1);
    assign nbits_s     = 4'd7 + {3'd0, eight} + {3'd0, pen};

    // Bits enter at the top, so a short frame is right-aligned by shifting out the unused low end.
    assign frame_s   = shreg_r >> (4'd9 - nbits_s);
    assign data_s    = eight ? frame_s[7:0] : {1'b0, frame_s[6:0]};
    assign par_bit_s = eight ? frame_s[8] : frame_s[7];
    assign perr_s    = pen & (parity8(data_s) ^ par_bit_s ^ ohel);

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_nxt_s   = state_r;
        tick_nxt_s    = tick_r;
        bit_idx_nxt_s = bit_idx_r;
        shreg_nxt_s   = shreg_r;
        armed_nxt_s   = armed_r;
        load_s        = 1'b0;
        case (state_r)
            IDLE: begin
                tick_nxt_s = {K_W{1'b0}};
                // A start is only accepted after the line has been seen idle, so a held break cannot retrigger.
                if (rx_s == RX_IDLE_LVL) begin
                    armed_nxt_s = 1'b1;
                end else if (armed_r) begin
                    armed_nxt_s = 1'b0;
                    state_nxt_s = START;
                end else begin
                    armed_nxt_s = 1'b0;
                end
            end
            START: begin
                if (tick_r == half_last_s) begin
                    tick_nxt_s    = {K_W{1'b0}};
                    bit_idx_nxt_s = 4'd0;
                    if (rx_s == RX_IDLE_LVL) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    tick_nxt_s = tick_r + K_W'(1);
                end
            end
            DATA: begin
                if (tick_r == bit_last_s) begin
                    tick_nxt_s    = {K_W{1'b0}};
                    shreg_nxt_s   = {rx_s, shreg_r[8:1]};
                    bit_idx_nxt_s = bit_idx_r + 4'd1;
                    if (bit_idx_r == (nbits_s - 4'd1)) begin
                        state_nxt_s = STOP;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    tick_nxt_s = tick_r + K_W'(1);
                end
            end
            STOP: begin
                if (tick_r == bit_last_s) begin
                    tick_nxt_s  = {K_W{1'b0}};
                    load_s      = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    tick_nxt_s = tick_r + K_W'(1);
                end
            end
            default: begin
                tick_nxt_s  = {K_W{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM, counter and shift-register state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tick_r    <= {K_W{1'b0}};
            bit_idx_r <= 4'd0;
            shreg_r   <= 9'd0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            tick_r    <= tick_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            armed_r   <= armed_nxt_s;
        end
    end

    // Held byte and status; a load in the same cycle as an acknowledge takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data <= 8'h00;
            rxrdy   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (load_s) begin
            rx_data <= data_s;
            rxrdy   <= 1'b1;
            perr    <= perr_s;
            ferr    <= ~rx_s;
            ovf     <= rxrdy & ~clr_rdy;
        end else if (clr_rdy) begin
            rxrdy <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            rxrdy <= rxrdy;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames, a frame-level expectation model
// compared every cycle, plus literal checks on data, flags and latency.
module tb_uart_rx_engine;

    logic        clk = 1'b0;
    logic        rst_n, rx, eight, pen, ohel, clr_rdy;
    logic [19:0] k;
    logic [7:0]  rx_data;
    logic        rxrdy, perr, ferr, ovf;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rise_cyc = -1;
    int last_c0  = 0;
    bit started  = 1'b0;

    typedef struct {
        int         t;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0, exp_ovf = 1'b0;

    uart_rx_engine #(.K_W(20), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .k       (k),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rxrdy   (rxrdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Expectation model: each queued frame result lands on its computed cycle.
    always @(posedge clk) begin
        cyc     = cyc + 1;
        started = 1'b1;
        if (!rst_n) begin
            q.delete();
            exp_data = 8'h00;
            exp_rdy  = 1'b0;
            exp_perr = 1'b0;
            exp_ferr = 1'b0;
            exp_ovf  = 1'b0;
        end else if (q.size() > 0 && q[0].t == cyc) begin
            cur      = q.pop_front();
            exp_ovf  = exp_rdy & ~clr_rdy;
            exp_rdy  = 1'b1;
            exp_data = cur.data;
            exp_perr = cur.perr;
            exp_ferr = cur.ferr;
        end else if (clr_rdy) begin
            exp_rdy  = 1'b0;
            exp_perr = 1'b0;
            exp_ferr = 1'b0;
            exp_ovf  = 1'b0;
        end
    end

    always @(posedge rxrdy) rise_cyc = cyc;

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            n_chk++;
            if (rx_data !== exp_data || rxrdy !== exp_rdy || perr !== exp_perr ||
                ferr !== exp_ferr || ovf !== exp_ovf) begin
                n_fail++;
                $display("FAIL model_cmp cyc %0d: got data=%h rdy=%b perr=%b ferr=%b ovf=%b, expected data=%h rdy=%b perr=%b ferr=%b ovf=%b",
                         cyc, rx_data, rxrdy, perr, ferr, ovf, exp_data, exp_rdy, exp_perr, exp_ferr, exp_ovf);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame and queues its expected result; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        int   kk, nd, c0;
        exp_t e;
        kk = int'(k);
        nd = 7 + int'(eight);
        @(posedge clk);
        #1;
        c0       = cyc;
        last_c0  = c0;
        e.t      = c0 + 3 + kk / 2 + (nd + int'(pen) + 1) * kk;
        e.data   = eight ? d : {1'b0, d[6:0]};
        e.ferr   = ~sbit;
        e.perr   = pen && ((($countones(e.data) + int'(pbit)) % 2) != int'(ohel));
        q.push_back(e);
        rx = 1'b0;
        repeat (kk) @(posedge clk);
        for (int i = 0; i < nd; i++) begin
            #1 rx = d[i];
            repeat (kk) @(posedge clk);
        end
        if (pen) begin
            #1 rx = pbit;
            repeat (kk) @(posedge clk);
        end
        #1 rx = sbit;
        repeat (kk) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_rdy = 1'b1;
        @(posedge clk);
        #1 clr_rdy = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; k = 20'd16; eight = 1'b1; pen = 1'b0; ohel = 1'b0; clr_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_rxrdy", {31'd0, rxrdy}, 32'd0);
        chk("reset_data", {24'd0, rx_data}, 32'h00);
        repeat (5) @(posedge clk);

        // 8N1 byte
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("a5_data", {24'd0, rx_data}, 32'hA5);
        chk("a5_latency", rise_cyc - last_c0, 32'd155);
        chk("a5_flags", {29'd0, perr, ferr, ovf}, 32'd0);
        pulse_clr();

        // Even parity, correct then wrong
        pen = 1'b1; ohel = 1'b0;
        send_frame(8'h37, 1'b1, 1'b1);
        chk("par_ok_perr", {31'd0, perr}, 32'd0);
        chk("par_latency", rise_cyc - last_c0, 32'd171);
        pulse_clr();
        send_frame(8'h37, 1'b0, 1'b1);
        chk("par_bad_perr", {31'd0, perr}, 32'd1);
        chk("par_bad_data", {24'd0, rx_data}, 32'h37);
        pulse_clr();

        // 7-bit mode
        pen = 1'b0; eight = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1);
        chk("b7_data", {24'd0, rx_data}, 32'h55);
        chk("b7_latency", rise_cyc - last_c0, 32'd139);
        pulse_clr();
        eight = 1'b1;

        // Start-bit glitch
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        chk("glitch_rxrdy", {31'd0, rxrdy}, 32'd0);

        // Back-to-back overrun, then acknowledge
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("ovf_data", {24'd0, rx_data}, 32'h22);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        pulse_clr();
        chk("clr_rxrdy_ovf", {30'd0, rxrdy, ovf}, 32'd0);

        // Held break: one all-zero framing-error load, no restart while low
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (80) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        chk("break_ferr_data", {23'd0, ferr, rx_data}, 32'h100);
        pulse_clr();

        // Framing error on 0xC3
        send_frame(8'hC3, 1'b0, 1'b0);
        #1 rx = 1'b1;
        chk("ferr_flag", {30'd0, ferr, rxrdy}, 32'd3);
        chk("ferr_data", {24'd0, rx_data}, 32'hC3);
        repeat (10) @(posedge clk);

        // Reset mid-frame aborts the frame
        fork
            send_frame(8'hFF, 1'b0, 1'b1);
        join_none
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        chk("rst_mid_outputs", {20'd0, rx_data, rxrdy, perr, ferr, ovf}, 32'd0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
